// File: rtl/store_unit.sv
// Store executor: places store data into byte lanes and drives a word write port.
// Stores that straddle a word boundary are issued as two consecutive word writes.
package store_unit_pkg;
   typedef enum logic [1:0] {
      sk_sb      = 2'd0,
      sk_sh      = 2'd1,
      sk_sw      = 2'd2,
      sk_invalid = 2'd3
   } store_kind_t;
endpackage

module store_unit
   import store_unit_pkg::*;
#(
   parameter bit ALLOW_MISALIGNED = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  store_kind_t req_kind,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_data,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_ack,
   output logic        resp_valid,
   output logic        resp_fault
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WR0  = 2'd1,
      S_WR1  = 2'd2,
      S_RESP = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [63:0] r_wd64;
   logic [7:0]  r_st8;
   logic [29:0] r_word;
   logic        r_fault;

   logic [31:0] w_dmask;
   logic [3:0]  w_nmask;
   logic        w_misal;
   logic        w_bad;
   logic        w_fault;
   logic [63:0] w_wd64;
   logic [7:0]  w_st8;

   always_comb begin
      w_dmask = '0;
      w_nmask = '0;
      w_misal = 1'b0;
      w_bad   = 1'b0;
      case (req_kind)
         sk_sb: begin
            w_dmask = 32'h0000_00FF;
            w_nmask = 4'b0001;
         end
         sk_sh: begin
            w_dmask = 32'h0000_FFFF;
            w_nmask = 4'b0011;
            w_misal = req_addr[0];
         end
         sk_sw: begin
            w_dmask = '1;
            w_nmask = 4'b1111;
            w_misal = |req_addr[1:0];
         end
         default: w_bad = 1'b1;
      endcase
      // 64-bit lane image: upper half is the second word of a split store
      w_wd64  = {32'd0, req_data & w_dmask} << {req_addr[1:0], 3'b000};
      w_st8   = {4'd0, w_nmask} << req_addr[1:0];
      w_fault = w_bad | (!ALLOW_MISALIGNED && w_misal);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_wd64  <= '0;
         r_st8   <= '0;
         r_word  <= '0;
         r_fault <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == S_IDLE && req_valid) begin
            r_wd64  <= w_wd64;
            r_st8   <= w_st8;
            r_word  <= req_addr[31:2];
            r_fault <= w_fault;
         end
      end
   end

   always_comb begin
      w_next     = r_state;
      req_ready  = 1'b0;
      mem_req    = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      mem_wstrb  = '0;
      resp_valid = 1'b0;
      resp_fault = 1'b0;
      case (r_state)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) w_next = w_fault ? S_RESP : S_WR0;
         end
         S_WR0: begin
            mem_req   = 1'b1;
            mem_addr  = {r_word, 2'b00};
            mem_wdata = r_wd64[31:0];
            mem_wstrb = r_st8[3:0];
            if (mem_ack) w_next = (|r_st8[7:4]) ? S_WR1 : S_RESP;
         end
         S_WR1: begin
            mem_req   = 1'b1;
            mem_addr  = {r_word + 30'd1, 2'b00};
            mem_wdata = r_wd64[63:32];
            mem_wstrb = r_st8[7:4];
            if (mem_ack) w_next = S_RESP;
         end
         S_RESP: begin
            resp_valid = 1'b1;
            resp_fault = r_fault;
            w_next     = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_store_unit.sv
// Directed bench for store_unit: lane placement, split/wrap, wait states,
// faults and mid-transaction reset, plus a strict-alignment instance.
module tb_store_unit;
   import store_unit_pkg::*;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   store_kind_t req_kind;
   logic [31:0] req_addr;
   logic [31:0] req_data;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ack;
   logic        resp_valid;
   logic        resp_fault;

   logic        na_req_valid;
   logic        na_req_ready;
   store_kind_t na_req_kind;
   logic [31:0] na_req_addr;
   logic [31:0] na_req_data;
   logic        na_mem_req;
   logic [31:0] na_mem_addr;
   logic [31:0] na_mem_wdata;
   logic [3:0]  na_mem_wstrb;
   logic        na_mem_ack;
   logic        na_resp_valid;
   logic        na_resp_fault;

   int unsigned n_tests;
   int unsigned n_fail;

   store_unit #(.ALLOW_MISALIGNED(1'b1)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
      .req_addr(req_addr), .req_data(req_data),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb), .mem_ack(mem_ack),
      .resp_valid(resp_valid), .resp_fault(resp_fault)
   );

   store_unit #(.ALLOW_MISALIGNED(1'b0)) dut_na (
      .clk(clk), .rst(rst),
      .req_valid(na_req_valid), .req_ready(na_req_ready), .req_kind(na_req_kind),
      .req_addr(na_req_addr), .req_data(na_req_data),
      .mem_req(na_mem_req), .mem_addr(na_mem_addr), .mem_wdata(na_mem_wdata),
      .mem_wstrb(na_mem_wstrb), .mem_ack(na_mem_ack),
      .resp_valid(na_resp_valid), .resp_fault(na_resp_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Presents a request at a falling edge; it is accepted on the next rising edge.
   task automatic issue(input store_kind_t k, input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      check("ready_before_accept", 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_kind  = k;
      req_addr  = a;
      req_data  = d;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic chk_access(input string tag, input logic [31:0] a, input logic [3:0] s,
                             input logic [31:0] d);
      @(negedge clk);
      check({tag, "_req"},   32'(mem_req), 32'd1);
      check({tag, "_addr"},  mem_addr, a);
      check({tag, "_strb"},  32'(mem_wstrb), 32'(s));
      check({tag, "_wdata"}, mem_wdata, d);
      check({tag, "_rdy"},   32'(req_ready), 32'd0);
      check({tag, "_rv"},    32'(resp_valid), 32'd0);
   endtask

   task automatic chk_resp(input string tag, input logic f);
      @(negedge clk);
      check({tag, "_rv"},    32'(resp_valid), 32'd1);
      check({tag, "_rf"},    32'(resp_fault), 32'(f));
      check({tag, "_mreq"},  32'(mem_req), 32'd0);
      @(negedge clk);
      check({tag, "_rdy"},   32'(req_ready), 32'd1);
      check({tag, "_rv_end"}, 32'(resp_valid), 32'd0);
   endtask

   task automatic chk_reset_outs(input string tag);
      check({tag, "_rdy"},   32'(req_ready), 32'd1);
      check({tag, "_mreq"},  32'(mem_req), 32'd0);
      check({tag, "_addr"},  mem_addr, 32'd0);
      check({tag, "_wdata"}, mem_wdata, 32'd0);
      check({tag, "_strb"},  32'(mem_wstrb), 32'd0);
      check({tag, "_rv"},    32'(resp_valid), 32'd0);
      check({tag, "_rf"},    32'(resp_fault), 32'd0);
   endtask

   initial begin
      n_tests      = 0;
      n_fail       = 0;
      rst          = 1'b0;
      req_valid    = 1'b0;
      req_kind     = sk_sb;
      req_addr     = '0;
      req_data     = '0;
      mem_ack      = 1'b1;
      na_req_valid = 1'b0;
      na_req_kind  = sk_sb;
      na_req_addr  = '0;
      na_req_data  = '0;
      na_mem_ack   = 1'b1;

      repeat (2) @(negedge clk);
      chk_reset_outs("reset");
      rst = 1'b1;

      // SB into the top lane
      issue(sk_sb, 32'h0000_1003, 32'hAABB_CCDD);
      chk_access("sb", 32'h0000_1000, 4'b1000, 32'hDD00_0000);
      chk_resp("sb", 1'b0);

      // SW crossing a word boundary
      issue(sk_sw, 32'h0000_2002, 32'h1122_3344);
      chk_access("sw_a0", 32'h0000_2000, 4'b1100, 32'h3344_0000);
      chk_access("sw_a1", 32'h0000_2004, 4'b0011, 32'h0000_1122);
      chk_resp("sw", 1'b0);

      // SH crossing the top of the address space
      issue(sk_sh, 32'hFFFF_FFFF, 32'h0000_BEEF);
      chk_access("sh_a0", 32'hFFFF_FFFC, 4'b1000, 32'hEF00_0000);
      chk_access("sh_a1", 32'h0000_0000, 4'b0001, 32'h0000_00BE);
      chk_resp("sh", 1'b0);

      // Invalid kind faults without touching memory
      issue(sk_invalid, 32'h0000_3000, 32'hDEAD_BEEF);
      chk_resp("inv", 1'b1);

      // Aligned SW with three wait cycles
      mem_ack = 1'b0;
      issue(sk_sw, 32'h0000_4000, 32'hCAFE_F00D);
      for (int i = 0; i < 4; i++) begin
         chk_access($sformatf("wait%0d", i), 32'h0000_4000, 4'b1111, 32'hCAFE_F00D);
         if (i == 3) mem_ack = 1'b1;
      end
      chk_resp("wait", 1'b0);

      // Reset while the second half of a split store is pending
      issue(sk_sw, 32'h0000_2002, 32'h5566_7788);
      chk_access("rst_a0", 32'h0000_2000, 4'b1100, 32'h7788_0000);
      chk_access("rst_a1", 32'h0000_2004, 4'b0011, 32'h0000_5566);
      rst = 1'b0;
      #1;
      chk_reset_outs("rst_mid");
      @(negedge clk);
      rst = 1'b1;
      chk_reset_outs("rst_hold");
      @(negedge clk);
      check("rst_no_resp", 32'(resp_valid), 32'd0);

      // Normal SB after reset, upper data bits discarded
      issue(sk_sb, 32'h0000_0010, 32'h1234_5678);
      chk_access("post_rst", 32'h0000_0010, 4'b0001, 32'h0000_0078);
      chk_resp("post_rst", 1'b0);

      // Strict-alignment instance: odd SH faults, aligned SH is written
      @(negedge clk);
      na_req_valid = 1'b1;
      na_req_kind  = sk_sh;
      na_req_addr  = 32'h0000_0005;
      na_req_data  = 32'h0000_1234;
      @(posedge clk);
      #1;
      na_req_valid = 1'b0;
      @(negedge clk);
      check("na_mis_rv",   32'(na_resp_valid), 32'd1);
      check("na_mis_rf",   32'(na_resp_fault), 32'd1);
      check("na_mis_mreq", 32'(na_mem_req), 32'd0);
      @(negedge clk);
      check("na_mis_rdy",  32'(na_req_ready), 32'd1);
      check("na_mis_mreq2", 32'(na_mem_req), 32'd0);

      na_req_valid = 1'b1;
      na_req_kind  = sk_sh;
      na_req_addr  = 32'h0000_0006;
      na_req_data  = 32'hFFFF_1234;
      @(posedge clk);
      #1;
      na_req_valid = 1'b0;
      @(negedge clk);
      check("na_al_mreq",  32'(na_mem_req), 32'd1);
      check("na_al_addr",  na_mem_addr, 32'h0000_0004);
      check("na_al_strb",  32'(na_mem_wstrb), 32'(4'b1100));
      check("na_al_wdata", na_mem_wdata, 32'h1234_0000);
      @(negedge clk);
      check("na_al_rv",    32'(na_resp_valid), 32'd1);
      check("na_al_rf",    32'(na_resp_fault), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/store_unit.md
# store_unit

Memory-side executor for decoded store instructions. Accepts one store request per transaction: a `store_kind_t` kind (`sk_sb`, `sk_sh`, `sk_sw`, `sk_invalid`), a byte address and register data. Drives a word-oriented memory write port with byte strobes and splits stores that cross a word boundary into two word writes. Returns a one-cycle completion or fault to the pipeline.

## Interface
- `ALLOW_MISALIGNED`, default 1: 1 splits word-crossing stores into two accesses; 0 faults on any non-naturally-aligned store.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset; one clock domain.
- `req_valid`  in  1  store request present.
- `req_ready`  out  1  unit can accept a request; high only in IDLE.
- `req_kind`  in  `store_kind_t`  decoded store kind.
- `req_addr`  in  32  byte address.
- `req_data`  in  32  store data, LSB-justified.
- `mem_req`  out  1  memory write request; held until acknowledged.
- `mem_addr`  out  32  word-aligned address; bits [1:0] are always 0.
- `mem_wdata`  out  32  lane-positioned write data.
- `mem_wstrb`  out  4  byte enables; bit i enables bits [8i+7:8i].
- `mem_ack`  in  1  write accepted; sampled only while `mem_req`=1.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_fault`  out  1  qualifies `resp_valid`: invalid kind or disallowed misalignment.

## Operation
- States: IDLE, WR0, WR1, RESP.
- IDLE:
  - `req_ready`=1.
  - Request is accepted on an edge where `req_valid`=1; kind, address and data are captured.
- Size n: 1 for `sk_sb`, 2 for `sk_sh`, 4 for `sk_sw`. Offset a = `req_addr[1:0]`.
- Lane placement over 64 bits:
  - wd64 = zero-extend(data masked to n bytes) << 8a.
  - st8 = ((1<<n)-1) << a.
  - Access 0: address {addr[31:2],2'b00}, data wd64[31:0], strobes st8[3:0].
  - Access 1 is needed iff st8[7:4]≠0: address = access-0 address + 4, mod 2^32 (wraps); data wd64[63:32], strobes st8[7:4].
- Transitions from IDLE on accept:
  - `sk_invalid` → RESP with fault; no memory access.
  - `ALLOW_MISALIGNED`=0 and a mod n≠0 → RESP with fault; no memory access.
  - Otherwise → WR0.
- WR0: `mem_req`=1 with access-0 fields. On `mem_ack`: go to WR1 if access 1 is needed, else RESP.
- WR1: `mem_req`=1 with access-1 fields. On `mem_ack` → RESP.
- RESP: `resp_valid`=1 for exactly one cycle, with `resp_fault` set as decided. Next state IDLE.
- `mem_wdata` lanes whose strobe is 0 are driven 0. Data bits above n bytes are ignored.
- `mem_addr`, `mem_wdata` and `mem_wstrb` are stable for the whole time `mem_req`=1.
- When `mem_req`=0 they are 0.

## Timing
- All outputs are registered or decoded from state only; no combinational path from any input to any output.
- Reset (async, `rst`=0): state IDLE. `req_ready`=1. `mem_req`, `mem_addr`, `mem_wdata`, `mem_wstrb`, `resp_valid` and `resp_fault` are all 0.
- Reset asserted mid-transaction:
  - `mem_req` drops immediately and the transaction is abandoned with no response.
  - A partially completed split store is not rolled back.
- Aligned store, accepted at edge T, `mem_ack`=1 in the first WR0 cycle:
  - `mem_req` is high in cycle T+1.
  - `resp_valid` is high in cycle T+2.
  - `req_ready` is high again in cycle T+3.
- Split store, zero-wait ack: WR0 in T+1, WR1 in T+2, `resp_valid` in T+3.
- Fault: `resp_valid`=1 and `resp_fault`=1 in T+1; `mem_req` never rises.
- Each wait cycle (`mem_ack`=0 while `mem_req`=1) adds exactly one cycle.
- `mem_ack` while `mem_req`=0 is ignored.
- `req_valid` outside IDLE is ignored; the requester must hold it until it sees `req_ready`.

## Test plan
- SB, addr 0x0000_1003, data 0xAABB_CCDD, zero-wait ack → one access: `mem_addr`=0x1000, `mem_wstrb`=4'b1000, `mem_wdata`=0xDD00_0000; `resp_valid` 2 cycles after accept, `resp_fault`=0.
- SW, addr 0x0000_2002, data 0x1122_3344 → access 0: 0x2000 / 4'b1100 / 0x3344_0000; access 1: 0x2004 / 4'b0011 / 0x0000_1122; `resp_valid` 3 cycles after accept.
- SH, addr 0xFFFF_FFFF, data 0x0000_BEEF → access 0: 0xFFFF_FFFC / 4'b1000 / 0xEF00_0000; access 1: 0x0000_0000 / 4'b0001 / 0x0000_00BE (address wrap).
- `sk_invalid`, any addr/data → `resp_valid`=`resp_fault`=1 one cycle after accept; `mem_req` stays 0.
- SW, addr 0x4000, `mem_ack` held low 3 cycles → `mem_req`/`mem_addr`/`mem_wstrb`/`mem_wdata` (0x4000/4'b1111/data) stable for 4 cycles; `req_ready`=0 throughout; `resp_valid` follows the ack by one cycle.
- `rst` pulsed low during WR1 → `mem_req`=0 immediately, no `resp_valid`; all outputs at reset values; next SB after reset completes normally. With `ALLOW_MISALIGNED`=0, SH at 0x5 → fault, no access.
